dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter (0 = memory read, 1 = write-back) in front of a single data-memory port.
// Define DMEM_ARB_WRITE_PRIORITY_EN to make requester 1 win every tie instead of round-robin.
module dmem_port_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [63:0]  req_address,
  input  logic [1:0]   req_wr_en,
  input  logic [127:0] req_wr_data,
  input  logic [7:0]   req_wr_size,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [63:0]  rsp_read_data,
  output logic         dmem_valid,
  input  logic         dmem_ready,
  output logic [31:0]  dmem_address,
  output logic         dmem_wr_en,
  output logic [63:0]  dmem_wr_data,
  output logic [3:0]   dmem_wr_size,
  input  logic         dmem_dp_valid,
  output logic         dmem_dp_ready,
  input  logic [63:0]  dmem_dp_read_data
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_owner;
  logic        r_lastGrant;
  logic        w_winner;
  logic        w_grantDone;
  logic [31:0] w_selAddr;
  logic        w_selWrEn;
  logic [63:0] w_selWrData;
  logic [3:0]  w_selWrSize;

  assign w_selAddr   = r_owner ? req_address[63:32]  : req_address[31:0];
  assign w_selWrEn   = r_owner ? req_wr_en[1]        : req_wr_en[0];
  assign w_selWrData = r_owner ? req_wr_data[127:64] : req_wr_data[63:0];
  assign w_selWrSize = r_owner ? req_wr_size[7:4]    : req_wr_size[3:0];

`ifdef DMEM_ARB_WRITE_PRIORITY_EN
  assign w_winner = req_valid[1];
`else
  // A lone requester wins outright; a tie goes to whoever was not served last.
  assign w_winner = (req_valid == 2'b11) ? ~r_lastGrant : req_valid[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_nextState == ADDR)
        r_owner <= w_winner;
      if (w_grantDone)
        r_lastGrant <= r_owner;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grantDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid && !flush)
          w_nextState = ADDR;
      end
      ADDR: begin
        if (flush) begin
          w_nextState = IDLE;
        end else if (dmem_ready) begin
          if (w_selWrEn) begin
            w_nextState = IDLE;
            w_grantDone = 1'b1;
          end else begin
            w_nextState = DATA;
          end
        end
      end
      DATA: begin
        // A flush that coincides with the data handshake still lets the data through.
        if (dmem_dp_valid && rsp_ready[r_owner]) begin
          w_nextState = IDLE;
          w_grantDone = 1'b1;
        end else if (flush) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_dp_valid) begin
          w_nextState = IDLE;
          w_grantDone = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_read_data = 64'd0;
    dmem_valid    = 1'b0;
    dmem_address  = 32'd0;
    dmem_wr_en    = 1'b0;
    dmem_wr_data  = 64'd0;
    dmem_wr_size  = 4'd0;
    dmem_dp_ready = 1'b0;
    case (r_state)
      ADDR: begin
        dmem_valid         = ~flush;
        dmem_address       = w_selAddr;
        dmem_wr_en         = w_selWrEn;
        dmem_wr_data       = w_selWrData;
        dmem_wr_size       = w_selWrSize;
        req_ready[r_owner] = ~flush & dmem_ready;
      end
      DATA: begin
        rsp_valid[r_owner] = dmem_dp_valid;
        dmem_dp_ready      = rsp_ready[r_owner];
        rsp_read_data      = dmem_dp_read_data;
      end
      DRAIN: begin
        // Swallow the orphaned read beat so the memory side is never left hanging.
        dmem_dp_ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, hand-written corner sequences and a
// randomized run scored against a transaction-level reference model.
module tb_dmem_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [63:0]  req_address;
  logic [1:0]   req_wr_en;
  logic [127:0] req_wr_data;
  logic [7:0]   req_wr_size;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [63:0]  rsp_read_data;
  logic         dmem_valid;
  logic         dmem_ready;
  logic [31:0]  dmem_address;
  logic         dmem_wr_en;
  logic [63:0]  dmem_wr_data;
  logic [3:0]   dmem_wr_size;
  logic         dmem_dp_valid;
  logic         dmem_dp_ready;
  logic [63:0]  dmem_dp_read_data;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDR0 = 32'h0000_1000;
  localparam logic [31:0] ADDR1 = 32'h0000_2000;
  localparam logic [63:0] DATA0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DATA1 = 64'h5555_6666_7777_8888;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_wr_en(req_wr_en), .req_wr_data(req_wr_data), .req_wr_size(req_wr_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read_data(rsp_read_data),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_address(dmem_address),
    .dmem_wr_en(dmem_wr_en), .dmem_wr_data(dmem_wr_data), .dmem_wr_size(dmem_wr_size),
    .dmem_dp_valid(dmem_dp_valid), .dmem_dp_ready(dmem_dp_ready),
    .dmem_dp_read_data(dmem_dp_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqWrEn;
    logic        dmemReady;
    logic        dpValid;
    logic [63:0] dpData;
    logic [1:0]  rspReady;
    logic        flush;
    logic        expDmemValid;
    logic [31:0] expAddr;
    logic [1:0]  expReqReady;
    logic [1:0]  expRspValid;
    logic        expDpReady;
    logic [63:0] expRdData;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic rst, logic [1:0] rv, logic [1:0] we, logic dr, logic dpv,
                                 logic [63:0] dpd, logic [1:0] rr, logic fl, logic eDv,
                                 logic [31:0] eAddr, logic [1:0] eRrdy, logic [1:0] eRsv,
                                 logic eDpr, logic [63:0] eRd);
    vec_t v;
    v.rst = rst; v.reqValid = rv; v.reqWrEn = we; v.dmemReady = dr; v.dpValid = dpv;
    v.dpData = dpd; v.rspReady = rr; v.flush = fl; v.expDmemValid = eDv; v.expAddr = eAddr;
    v.expReqReady = eRrdy; v.expRspValid = eRsv; v.expDpReady = eDpr; v.expRdData = eRd;
    return v;
  endfunction

  // Who wins a tie given the previous grant; first tie after reset sees lastGrant = 1.
  function automatic logic tieWinner(logic last);
`ifdef DMEM_ARB_WRITE_PRIORITY_EN
    return 1'b1;
`else
    return ~last;
`endif
  endfunction

  function automatic logic pickWinner(logic [1:0] v, logic last);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return tieWinner(last);
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clearInputs();
    flush = 1'b0; req_valid = 2'b00; req_wr_en = 2'b00; dmem_ready = 1'b0;
    dmem_dp_valid = 1'b0; dmem_dp_read_data = 64'd0; rsp_ready = 2'b00;
    req_address = {ADDR1, ADDR0}; req_wr_data = {DATA1, DATA0}; req_wr_size = 8'hF3;
  endtask

  // Ends on a falling edge with reset released.
  task automatic doReset();
    reset = 1'b0;
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rst) doReset();
    req_valid = v.reqValid; req_wr_en = v.reqWrEn; dmem_ready = v.dmemReady;
    dmem_dp_valid = v.dpValid; dmem_dp_read_data = v.dpData; rsp_ready = v.rspReady;
    flush = v.flush;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("vec%0d dmem_valid", idx), {63'd0, dmem_valid}, {63'd0, v.expDmemValid});
    checkVal($sformatf("vec%0d dmem_address", idx), {32'd0, dmem_address}, {32'd0, v.expAddr});
    checkVal($sformatf("vec%0d req_ready", idx), {62'd0, req_ready}, {62'd0, v.expReqReady});
    checkVal($sformatf("vec%0d rsp_valid", idx), {62'd0, rsp_valid}, {62'd0, v.expRspValid});
    checkVal($sformatf("vec%0d dmem_dp_ready", idx), {63'd0, dmem_dp_ready}, {63'd0, v.expDpReady});
    checkVal($sformatf("vec%0d rsp_read_data", idx), rsp_read_data, v.expRdData);
  endtask

  // Transaction-level reference model state and requester/memory bookkeeping.
  logic        mBusy, mAddrDone, mDrain, mOwner, mLast;
  logic        pValid[2];
  logic [31:0] pAddr[2];
  logic        pWr[2];
  logic [63:0] pData[2];
  logic [3:0]  pSize[2];

  initial begin
    logic last;
    logic own;
    reset = 1'b0;
    clearInputs();

    // Single read, then requester-1 read with rsp_ready gating, then write ties.
    vecs.push_back(mkVec(1, 2'b01, 2'b00, 1, 0, 64'd0, 2'b01, 0, 0, 32'd0, 2'b00, 2'b00, 0, 64'd0));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 1, 0, 64'd0, 2'b01, 0, 1, ADDR0, 2'b01, 2'b00, 0, 64'd0));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 1, 0, 64'd0, 2'b01, 0, 0, 32'd0, 2'b00, 2'b00, 1, 64'd0));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 1, 1, 64'hDEADBEEF, 2'b01, 0, 0, 32'd0, 2'b00, 2'b01, 1, 64'hDEADBEEF));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 1, 1, 64'h1234, 2'b01, 0, 0, 32'd0, 2'b00, 2'b00, 0, 64'd0));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 1, 0, 64'd0, 2'b00, 0, 0, 32'd0, 2'b00, 2'b00, 0, 64'd0));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 1, 0, 64'd0, 2'b00, 0, 1, ADDR1, 2'b10, 2'b00, 0, 64'd0));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 1, 1, 64'hCAFE, 2'b01, 0, 0, 32'd0, 2'b00, 2'b10, 0, 64'hCAFE));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 1, 1, 64'hBEEF, 2'b10, 0, 0, 32'd0, 2'b00, 2'b10, 1, 64'hBEEF));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 1, 0, 64'd0, 2'b00, 0, 0, 32'd0, 2'b00, 2'b00, 0, 64'd0));
    last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      own = tieWinner(last);
      vecs.push_back(mkVec(k == 0, 2'b11, 2'b11, 1, 0, 64'd0, 2'b00, 0, 0, 32'd0, 2'b00, 2'b00, 0, 64'd0));
      vecs.push_back(mkVec(0, 2'b11, 2'b11, 1, 0, 64'd0, 2'b00, 0, 1, own ? ADDR1 : ADDR0,
                           own ? 2'b10 : 2'b01, 2'b00, 0, 64'd0));
      last = own;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1 checkOutput(vecs[i], i);
    end

    // Backpressure: requester 1 write waits five cycles for dmem_ready.
    @(negedge clk);
    doReset();
    req_valid = 2'b10; req_wr_en = 2'b10;
    #1 checkVal("bp idle dmem_valid", {63'd0, dmem_valid}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkVal("bp dmem_valid", {63'd0, dmem_valid}, 64'd1);
      checkVal("bp address", {32'd0, dmem_address}, {32'd0, ADDR1});
      checkVal("bp wr_data", dmem_wr_data, DATA1);
      checkVal("bp wr_size", {60'd0, dmem_wr_size}, 64'hF);
      checkVal("bp req_ready", {62'd0, req_ready}, 64'd0);
    end
    dmem_ready = 1'b1;
    #1 checkVal("bp accept req_ready", {62'd0, req_ready}, 64'd2);
    @(negedge clk);
    req_valid = 2'b00;
    #1 checkVal("bp back to idle", {63'd0, dmem_valid}, 64'd0);

    // Flush during the data phase leaves an orphan beat that must be drained silently.
    @(negedge clk);
    doReset();
    req_valid = 2'b01; req_wr_en = 2'b00; dmem_ready = 1'b1; rsp_ready = 2'b01;
    @(negedge clk);
    #1 checkVal("fl addr handshake", {62'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 2'b00; flush = 1'b1; rsp_ready = 2'b00;
    #1 checkVal("fl data rsp_valid", {62'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 checkVal("fl drain dp_ready", {63'd0, dmem_dp_ready}, 64'd1);
    @(negedge clk);
    dmem_dp_valid = 1'b1; dmem_dp_read_data = 64'h55; rsp_ready = 2'b01;
    #1;
    checkVal("fl drain rsp_valid", {62'd0, rsp_valid}, 64'd0);
    checkVal("fl drain dp_ready beat", {63'd0, dmem_dp_ready}, 64'd1);
    checkVal("fl drain read_data", rsp_read_data, 64'd0);
    @(negedge clk);
    dmem_dp_valid = 1'b0; req_valid = 2'b01; req_wr_en = 2'b01;
    #1 checkVal("fl idle after drain", {63'd0, dmem_dp_ready}, 64'd0);
    @(negedge clk);
    #1 checkVal("fl new request issued", {63'd0, dmem_valid}, 64'd1);

    // Asynchronous reset in the address phase, then re-arbitration of the held tie.
    @(negedge clk);
    doReset();
    req_valid = 2'b11; req_wr_en = 2'b11; dmem_ready = 1'b0;
    @(negedge clk);
    #1 checkVal("rst addr before", {32'd0, dmem_address}, {32'd0, tieWinner(1'b1) ? ADDR1 : ADDR0});
    dmem_ready = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkVal("rst async dmem_valid", {63'd0, dmem_valid}, 64'd0);
    checkVal("rst async req_ready", {62'd0, req_ready}, 64'd0);
    checkVal("rst async address", {32'd0, dmem_address}, 64'd0);
    checkVal("rst async wr_en", {63'd0, dmem_wr_en}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 checkVal("rst idle after release", {63'd0, dmem_valid}, 64'd0);
    @(negedge clk);
    #1;
    checkVal("rst rearb dmem_valid", {63'd0, dmem_valid}, 64'd1);
    checkVal("rst rearb address", {32'd0, dmem_address}, {32'd0, tieWinner(1'b1) ? ADDR1 : ADDR0});

    // Randomized traffic scored against the reference model.
    @(negedge clk);
    doReset();
    mBusy = 0; mAddrDone = 0; mDrain = 0; mOwner = 0; mLast = 1;
    for (int r = 0; r < 2; r++) pValid[r] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        eDv, eWe;
      logic [31:0] eAddr;
      logic [63:0] eData, eRd;
      logic [3:0]  eSize;
      logic [1:0]  eRrdy, eRsv;
      logic        eDpr;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pValid[r] && $urandom_range(0, 2) == 0) begin
          pValid[r] = 1'b1;
          pAddr[r]  = $urandom;
          pWr[r]    = (r == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
          pData[r]  = {$urandom, $urandom};
          pSize[r]  = 4'($urandom_range(0, 15));
        end
      end
      req_valid   = {pValid[1], pValid[0]};
      req_address = {pAddr[1], pAddr[0]};
      req_wr_en   = {pWr[1], pWr[0]};
      req_wr_data = {pData[1], pData[0]};
      req_wr_size = {pSize[1], pSize[0]};
      flush             = ($urandom_range(0, 9) == 0);
      dmem_ready        = 1'($urandom_range(0, 1));
      dmem_dp_valid     = ($urandom_range(0, 4) < 2);
      dmem_dp_read_data = {$urandom, $urandom};
      rsp_ready         = 2'($urandom_range(0, 3));

      eDv = 0; eWe = 0; eAddr = 0; eData = 0; eSize = 0; eRrdy = 0; eRsv = 0; eDpr = 0; eRd = 0;
      if (mBusy && !mAddrDone) begin
        eDv = !flush;
        eAddr = pAddr[mOwner]; eWe = pWr[mOwner]; eData = pData[mOwner]; eSize = pSize[mOwner];
        eRrdy[mOwner] = eDv && dmem_ready;
      end else if (mBusy && !mDrain) begin
        eRsv[mOwner] = dmem_dp_valid;
        eDpr = rsp_ready[mOwner];
        eRd = dmem_dp_read_data;
      end else if (mBusy) begin
        eDpr = 1'b1;
      end
      #1;
      checkVal("rnd dmem_valid", {63'd0, dmem_valid}, {63'd0, eDv});
      checkVal("rnd dmem_address", {32'd0, dmem_address}, {32'd0, eAddr});
      checkVal("rnd dmem_wr_en", {63'd0, dmem_wr_en}, {63'd0, eWe});
      checkVal("rnd dmem_wr_data", dmem_wr_data, eData);
      checkVal("rnd dmem_wr_size", {60'd0, dmem_wr_size}, {60'd0, eSize});
      checkVal("rnd req_ready", {62'd0, req_ready}, {62'd0, eRrdy});
      checkVal("rnd rsp_valid", {62'd0, rsp_valid}, {62'd0, eRsv});
      checkVal("rnd dmem_dp_ready", {63'd0, dmem_dp_ready}, {63'd0, eDpr});
      checkVal("rnd rsp_read_data", rsp_read_data, eRd);

      @(posedge clk);
      if (!mBusy) begin
        if (|req_valid && !flush) begin
          mBusy = 1; mAddrDone = 0; mDrain = 0;
          mOwner = pickWinner(req_valid, mLast);
        end
      end else if (!mAddrDone) begin
        if (flush) mBusy = 0;
        else if (dmem_ready) begin
          if (pWr[mOwner]) begin mBusy = 0; mLast = mOwner; end
          else mAddrDone = 1;
        end
      end else if (!mDrain) begin
        if (dmem_dp_valid && rsp_ready[mOwner]) begin mBusy = 0; mLast = mOwner; end
        else if (flush) mDrain = 1;
      end else if (dmem_dp_valid) begin
        mBusy = 0; mLast = mOwner;
      end
      for (int r = 0; r < 2; r++)
        if (eRrdy[r]) pValid[r] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
